// File: rtl/bit_serial_pair_driver_pkg.sv
// Shared types and defaults for the bit-serial pair driver.
package bit_serial_pair_driver_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/bit_serial_pair_driver_if.sv
// Operand/result and gate-stage signals between the pair driver and its surroundings.
interface bit_serial_pair_driver_if #(
   parameter int unsigned WIDTH = bit_serial_pair_driver_pkg::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             a_bit;
   logic             b_bit;
   logic             c_bit;
   logic             o_bit;
   logic [WIDTH-1:0] xor_word;
   logic [WIDTH-1:0] or_word;
   logic             done;

   modport slave (
      input  start, op_a, op_b, c_bit, o_bit,
      output busy, a_bit, b_bit, xor_word, or_word, done
   );

   modport master (
      output start, op_a, op_b, c_bit, o_bit,
      input  busy, a_bit, b_bit, xor_word, or_word, done
   );

endinterface

// File: rtl/bit_serial_pair_driver_serial_capture_reg.sv
// Right-shift register that inserts one serial bit at the MSB per enabled clock.
module serial_capture_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n_i,
   input  logic             shift_en_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] word_o
);

   logic [WIDTH-1:0] word_q, word_d;

   always_comb begin
      word_d = word_q;
      if (shift_en_i) word_d = {bit_i, word_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!clr_n_i) word_q <= '0;
      else          word_q <= word_d;
   end

   assign word_o = word_q;

endmodule

// File: rtl/bit_serial_pair_driver.sv
// Serialises two operands LSB-first into an external XOR/OR gate stage and
// reassembles the returned result bits into parallel words.
module bit_serial_pair_driver
   import bit_serial_pair_driver_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                    clk,
   input logic                    rst_n,
   bit_serial_pair_driver_if.slave bus
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic             accept;
   logic             shifting;

   assign shifting = (state_q == SHIFT);
   assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_a_q <= '0;
         shift_b_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = accept ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counter saturates at LAST so it never wraps; every accepted start clears it.
   always_comb begin
      cnt_d     = cnt_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      if (accept) begin
         cnt_d     = '0;
         shift_a_d = bus.op_a;
         shift_b_d = bus.op_b;
      end else if (shifting) begin
         if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
         shift_a_d = shift_a_q >> 1;
         shift_b_d = shift_b_q >> 1;
      end
   end

   always_comb begin
      bus.busy  = shifting;
      bus.done  = (state_q == DONE);
      bus.a_bit = shifting ? shift_a_q[0] : 1'b0;
      bus.b_bit = shifting ? shift_b_q[0] : 1'b0;
   end

   serial_capture_reg #(.WIDTH(WIDTH)) u_xor_cap (
      .clk        (clk),
      .clr_n_i    (rst_n),
      .shift_en_i (shifting),
      .bit_i      (bus.c_bit),
      .word_o     (bus.xor_word)
   );

   serial_capture_reg #(.WIDTH(WIDTH)) u_or_cap (
      .clk        (clk),
      .clr_n_i    (rst_n),
      .shift_en_i (shifting),
      .bit_i      (bus.o_bit),
      .word_o     (bus.or_word)
   );

endmodule

// File: tb/tb_bit_serial_pair_driver.sv
// Directed bench: an 8-bit and a 2-bit driver, each looped through a behavioural XOR/OR gate stage.
module tb_bit_serial_pair_driver;

   localparam int unsigned W  = 8;
   localparam int unsigned W2 = 2;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   bit_serial_pair_driver_if #(.WIDTH(W))  bus  ();
   bit_serial_pair_driver_if #(.WIDTH(W2)) bus2 ();

   bit_serial_pair_driver #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   bit_serial_pair_driver #(.WIDTH(W2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   // Gate stage: combinational XOR/OR on the serial bit pair.
   assign bus.c_bit  = bus.a_bit ^ bus.b_bit;
   assign bus.o_bit  = bus.a_bit | bus.b_bit;
   assign bus2.c_bit = bus2.a_bit ^ bus2.b_bit;
   assign bus2.o_bit = bus2.a_bit | bus2.b_bit;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a start for one edge; returns in cycle 1 of the operation.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_x, input logic [W-1:0] exp_o);
      start_op(a, b);
      repeat (W) tick();
      check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
      check_eq({tag, "_xor"}, 32'(bus.xor_word), 32'(exp_x));
      check_eq({tag, "_or"}, 32'(bus.or_word), 32'(exp_o));
      tick();
      check_eq({tag, "_done_low"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [W-1:0] pat;
      logic         seen;
      n_checks   = 0;
      n_pass     = 0;
      bus.start  = 1'b0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus2.start = 1'b0;
      bus2.op_a  = '0;
      bus2.op_b  = '0;

      // 1: reset, then idle with no start
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.busy || bus.done || bus.a_bit || bus.b_bit ||
             (bus.xor_word != '0) || (bus.or_word != '0)) seen = 1'b1;
         tick();
      end
      check_eq("idle_quiet", 32'(seen), 32'd0);
      check_eq("rst_xor", 32'(bus.xor_word), 32'h00);
      check_eq("rst_or", 32'(bus.or_word), 32'h00);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);

      // 2: single op, bit-by-bit A stream
      pat = 8'hA5;
      start_op(8'hA5, 8'h3C);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("t2_busy%0d", i), 32'(bus.busy), 32'd1);
         check_eq($sformatf("t2_abit%0d", i), 32'(bus.a_bit), 32'(pat[i]));
         tick();
      end
      check_eq("t2_done", 32'(bus.done), 32'd1);
      check_eq("t2_busy_off", 32'(bus.busy), 32'd0);
      check_eq("t2_xor", 32'(bus.xor_word), 32'h99);
      check_eq("t2_or", 32'(bus.or_word), 32'hBD);
      tick();
      tick();
      check_eq("t2_hold_done", 32'(bus.done), 32'd0);
      check_eq("t2_hold_xor", 32'(bus.xor_word), 32'h99);
      check_eq("t2_hold_or", 32'(bus.or_word), 32'hBD);
      check_eq("t2_idle_abit", 32'(bus.a_bit), 32'd0);

      // 3: start while busy is ignored
      start_op(8'hFF, 8'h00);
      tick();
      tick();
      start_op(8'h12, 8'h34);
      repeat (5) tick();
      check_eq("t3_done", 32'(bus.done), 32'd1);
      check_eq("t3_xor", 32'(bus.xor_word), 32'hFF);
      check_eq("t3_or", 32'(bus.or_word), 32'hFF);
      tick();

      // 4: back-to-back with start held high
      bus.op_a  = 8'h0F;
      bus.op_b  = 8'hF0;
      bus.start = 1'b1;
      repeat (9) tick();
      check_eq("t4_done1", 32'(bus.done), 32'd1);
      check_eq("t4_xor1", 32'(bus.xor_word), 32'hFF);
      check_eq("t4_or1", 32'(bus.or_word), 32'hFF);
      bus.op_a = 8'hAA;
      bus.op_b = 8'h55;
      tick();
      check_eq("t4_no_bubble", 32'(bus.busy), 32'd1);
      check_eq("t4_abit0", 32'(bus.a_bit), 32'd0);
      check_eq("t4_bbit0", 32'(bus.b_bit), 32'd1);
      repeat (7) tick();
      check_eq("t4_not_yet", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      tick();
      check_eq("t4_done2", 32'(bus.done), 32'd1);
      check_eq("t4_xor2", 32'(bus.xor_word), 32'hFF);
      check_eq("t4_or2", 32'(bus.or_word), 32'hFF);
      tick();
      check_eq("t4_idle", 32'(bus.busy), 32'd0);

      // 5: reset mid-operation
      start_op(8'hC3, 8'h81);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("t5_busy", 32'(bus.busy), 32'd0);
      check_eq("t5_xor", 32'(bus.xor_word), 32'h00);
      check_eq("t5_or", 32'(bus.or_word), 32'h00);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done || bus.busy) seen = 1'b1;
         tick();
      end
      check_eq("t5_no_done", 32'(seen), 32'd0);
      run_op("t5_next", 8'h01, 8'h01, 8'h00, 8'h01);

      // 6: edge values
      run_op("t6_zero", 8'h00, 8'h00, 8'h00, 8'h00);
      run_op("t6_ones", 8'hFF, 8'hFF, 8'h00, 8'hFF);

      // 6b: WIDTH=2 build
      bus2.op_a  = 2'b10;
      bus2.op_b  = 2'b11;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      check_eq("w2_busy1", 32'(bus2.busy), 32'd1);
      tick();
      check_eq("w2_cycle2_done", 32'(bus2.done), 32'd0);
      tick();
      check_eq("w2_done", 32'(bus2.done), 32'd1);
      check_eq("w2_xor", 32'(bus2.xor_word), 32'h1);
      check_eq("w2_or", 32'(bus2.or_word), 32'h3);
      tick();
      check_eq("w2_idle", 32'(bus2.done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
